// File: rtl/ram_stream_reader_pkg.sv
// Shared state encoding and output-FIFO sizing for the RAM stream reader.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry output FIFO with fall-through: an arriving word is visible at the
// head in the same cycle when the FIFO is empty, and is stored if not taken.
module stream_skid_fifo
  import ram_stream_reader_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  wr_valid_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_ready_i,
  output logic                  rd_valid_o,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  localparam int PtrW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       head_q, tail_q;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  empty, pop;

  assign empty      = (count_q == '0);
  assign rd_valid_o = !empty || wr_valid_i;
  assign rd_data_o  = !empty ? mem_q[head_q] : (wr_valid_i ? wr_data_i : '0);
  assign pop        = rd_valid_o && rd_ready_i;
  assign count_d    = count_q + FIFO_CNT_W'(wr_valid_i) - FIFO_CNT_W'(pop);
  assign count_o    = count_q;

  // A bypassed word is still written and both pointers advance, keeping them aligned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_valid_i) begin
        mem_q[tail_q] <= wr_data_i;
        tail_q        <= tail_q + PtrW'(1);
      end
      if (pop) head_q <= head_q + PtrW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a (optionally looping) burst of words from a registered-output RAM
// and presents them as a ready/valid stream with a last marker per pass.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   length,
  input  logic              loop,
  output logic              busy,
  output logic              done,
  output logic              ram_rden,
  output logic [AWIDTH-1:0] ram_rdaddr,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic [DWIDTH-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast
);

  state_e                state_q, state_d;
  logic [AWIDTH-1:0]     base_q, addr_q, addr_d;
  logic [AWIDTH:0]       len_q, rdcnt_q, rdcnt_d;
  logic                  loop_q, inflight_q, inflight_last_q, done_q;
  logic                  load, issue, flush, zero_done, drain_done;
  logic                  room, last_read, beat;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [DWIDTH:0]       fifo_data;

  // Reads already issued plus words held must never exceed the FIFO depth.
  assign room      = (fifo_count + FIFO_CNT_W'(inflight_q)) < FIFO_CNT_W'(FIFO_DEPTH);
  assign last_read = (rdcnt_q == len_q - (AWIDTH + 1)'(1));
  assign beat      = m_tvalid && m_tready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rdcnt_d    = rdcnt_q;
    load       = 1'b0;
    issue      = 1'b0;
    flush      = 1'b0;
    zero_done  = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (length != '0) begin
            state_d = RUN;
            load    = 1'b1;
            addr_d  = base_addr;
            rdcnt_d = '0;
          end else begin
            zero_done = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (room) begin
          issue   = 1'b1;
          addr_d  = addr_q + AWIDTH'(1);
          rdcnt_d = rdcnt_q + (AWIDTH + 1)'(1);
          if (last_read) begin
            rdcnt_d = '0;
            if (loop_q) addr_d = base_q;
            else        state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (beat && m_tlast) begin
          state_d    = IDLE;
          drain_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rdcnt_q         <= '0;
      base_q          <= '0;
      len_q           <= '0;
      loop_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rdcnt_q         <= rdcnt_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && last_read;
      done_q          <= zero_done;
      if (load) begin
        base_q <= base_addr;
        len_q  <= length;
        loop_q <= loop;
      end
    end
  end

  stream_skid_fifo #(
    .WIDTH(DWIDTH + 1)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .flush_i   (flush),
    .wr_valid_i(inflight_q),
    .wr_data_i ({inflight_last_q, ram_dout}),
    .rd_ready_i(m_tready),
    .rd_valid_o(m_tvalid),
    .rd_data_o (fifo_data),
    .count_o   (fifo_count)
  );

  assign m_tdata    = fifo_data[DWIDTH-1:0];
  assign m_tlast    = fifo_data[DWIDTH];
  assign busy       = (state_q != IDLE);
  assign done       = done_q || drain_done;
  assign ram_rden   = issue;
  assign ram_rdaddr = addr_q;

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter DWIDTH, default 16: RAM word and stream data width.
REQ-002 SHALL have parameter AWIDTH, default 7: RAM address width; depth = 2**AWIDTH.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk, input, 1, rising-edge clock for all logic; reset_n, input, 1, async active-low reset.
REQ-004 SHALL have port start, input, 1: one-cycle pulse that launches a read burst when idle.
REQ-005 SHALL have port abort, input, 1: terminates the active burst.
REQ-006 SHALL have port base_addr, input, AWIDTH: first word address, sampled on start.
REQ-007 SHALL have port length, input, AWIDTH+1: word count 0..2**AWIDTH, sampled on start.
REQ-008 SHALL have port loop, input, 1: when high at start, the burst repeats until abort.
REQ-009 SHALL have port busy, output, 1: high from the accepted start until return to IDLE.
REQ-010 SHALL have port done, output, 1: one-cycle pulse on normal burst completion.
REQ-011 SHALL have port ram_rden, output, 1: read enable to the RAM read port.
REQ-012 SHALL have port ram_rdaddr, output, AWIDTH: read address to the RAM.
REQ-013 SHALL have port ram_dout, input, DWIDTH: registered RAM data, valid one cycle after ram_rden.
REQ-014 SHALL have ports m_tdata (output, DWIDTH), m_tvalid (output, 1), m_tready (input, 1) and m_tlast (output, 1): output stream.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-016 SHALL transition IDLE->RUN on start with length>0; in this case it SHALL latch base_addr, length and loop.
REQ-017 SHALL, on start with length=0, pulse done the next cycle, stay IDLE and emit no beats.
REQ-018 SHALL ignore start while busy.
REQ-019 SHALL issue ram_rden in RUN only when (reads in flight + words buffered) < 2; rdaddr SHALL start at base_addr and increment by 1 per issued read, modulo 2**AWIDTH.
REQ-020 SHALL capture ram_dout exactly one cycle after each ram_rden into a 2-entry output FIFO, so that no word is lost while m_tready is low.
REQ-021 SHALL present m_tdata from the FIFO head; a beat transfers when m_tvalid and m_tready are both high; m_tdata SHALL stay stable while m_tvalid is high and m_tready is low.
REQ-022 SHALL assert m_tlast on the beat carrying the final word of each pass (word index length-1).
REQ-023 SHALL, once the last read of a pass is issued: if loop=0, enter DRAIN; if loop=1, reload the address from base_addr and continue in RUN with no idle cycle.
REQ-024 SHALL, in DRAIN, go to IDLE and pulse done in the same cycle that the last beat transfers.
REQ-025 SHALL, on abort in RUN or DRAIN, stop issuing reads, flush the FIFO, discard any in-flight read data, deassert m_tvalid next cycle and enter IDLE; done SHALL NOT pulse.
REQ-026 SHALL, when abort and start occur in the same cycle, give abort priority; a start in IDLE is then ignored.
REQ-027 SHALL, with m_tready held high, sustain 1 beat per cycle; first m_tvalid SHALL appear 2 cycles after start.

Reset
REQ-028 SHALL, while reset_n is low: state=IDLE, busy=0, done=0, ram_rden=0, ram_rdaddr=0, m_tvalid=0, m_tlast=0, m_tdata=0, FIFO empty and in-flight count 0.
REQ-029 SHALL, on reset mid-burst, abandon the burst and produce no done pulse after release.

Structure
REQ-030 SHALL place the FSM state encoding and the FIFO depth constant (2) in a shared package.
REQ-031 SHALL instantiate the 2-entry output FIFO as a sub-module named stream_skid_fifo.

Verification
REQ-032 SHALL verify: RAM preloaded 0x0001,0xAAAA,0x5555,0xFFFF; start base=0 len=4 loop=0, m_tready=1 -> beats 0x0001,0xAAAA,0x5555,0xFFFF on consecutive cycles, tlast on 0xFFFF, done 1 cycle.
REQ-033 SHALL verify: base=126 len=4 -> rdaddr sequence 126,127,0,1.
REQ-034 SHALL verify: m_tready toggled 1-0-0-1 randomly over len=10 -> all 10 words in order, none dropped or duplicated, tdata stable while stalled.
REQ-035 SHALL verify: loop=1 len=3 -> pattern repeats with tlast every 3rd beat; abort after 7 beats -> m_tvalid low next cycle, busy low, no done.
REQ-036 SHALL verify: start with len=0 -> done pulse, no m_tvalid; start and abort in the same cycle -> stays IDLE.
REQ-037 SHALL verify: reset_n asserted mid-burst -> all outputs return to reset values immediately, next start behaves normally.
